// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic array controller
package systolic_pkg;

  localparam int SYS_N  = 4;
  localparam int SYS_KW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Cycles the last partial products need to ripple to the far corner cell.
  function automatic int drain_cycles(input int n);
    return n + 1;
  endfunction

  localparam int DRAIN_LEN = drain_cycles(SYS_N);

endpackage

// File: rtl/systolic_skew_gen.sv
// rtl/systolic_skew_gen.sv - registered diagonal skew of lane valids and operand indices
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int N  = SYS_N,
  parameter int KW = SYS_KW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [KW:0]     t,
  input  logic [KW-1:0]   k_len,
  output logic [N-1:0]    lane_vld,
  output logic [N*KW-1:0] lane_idx
);

  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [KW+1:0] LO = (KW+2)'(g);
    logic [KW+1:0] diff;
    logic          hit;
    logic          vld_q;
    logic [KW-1:0] idx_q;

    // A negative t-g wraps and sets the top bit, which rules the lane out.
    assign diff = {1'b0, t} - LO;
    assign hit  = en && !diff[KW+1] && (diff < {2'b00, k_len});

    always_ff @(posedge clk) begin
      if (!rst) begin
        vld_q <= 1'b0;
        idx_q <= '0;
      end else begin
        vld_q <= hit;
        idx_q <= hit ? diff[KW-1:0] : '0;
      end
    end

    assign lane_vld[g]           = vld_q;
    assign lane_idx[g*KW +: KW]  = idx_q;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - pass sequencer for an NxN output-stationary MAC array
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = SYS_N,
  parameter int KW = SYS_KW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            cap_en,
  output logic            cfg_err,
  output logic            pe_clr,
  output logic [N-1:0]    lane_vld,
  output logic [N*KW-1:0] lane_idx
);

  localparam logic [KW:0] DRAIN_LAST = (KW+1)'(drain_cycles(N) - 1);

  state_t        state;
  logic [KW:0]   t;
  logic [KW-1:0] k_reg;
  logic [KW:0]   feed_last;
  logic          sk_en;
  logic [KW:0]   sk_t;

  assign feed_last = {1'b0, k_reg} + (KW+1)'(N - 2);

  // The skew generator registers its outputs, so it is fed the next cycle's t.
  always_comb begin
    sk_en = !abort && ((state == ST_CLEAR) || (state == ST_FEED && t != feed_last));
    sk_t  = (state == ST_CLEAR) ? '0 : t + (KW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      t       <= '0;
      k_reg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cap_en  <= 1'b0;
      cfg_err <= 1'b0;
      pe_clr  <= 1'b1;
    end else begin
      done    <= 1'b0;
      cap_en  <= 1'b0;
      cfg_err <= 1'b0;
      pe_clr  <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        pe_clr <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              if (k_len == '0) begin
                cfg_err <= 1'b1;
              end else begin
                k_reg  <= k_len;
                state  <= ST_CLEAR;
                busy   <= 1'b1;
                pe_clr <= 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            state <= ST_FEED;
            t     <= '0;
          end
          ST_FEED: begin
            if (t == feed_last) begin
              state <= ST_DRAIN;
              t     <= '0;
            end else begin
              t <= t + (KW+1)'(1);
            end
          end
          ST_DRAIN: begin
            if (t == DRAIN_LAST) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              cap_en <= 1'b1;
            end else begin
              t <= t + (KW+1)'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  systolic_skew_gen #(.N(N), .KW(KW)) u_skew (
    .clk      (clk),
    .rst      (rst),
    .en       (sk_en),
    .t        (sk_t),
    .k_len    (k_reg),
    .lane_vld (lane_vld),
    .lane_idx (lane_idx)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed bench for systolic_ctrl with a 4x4 MAC array model
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy, done, cap_en, cfg_err, pe_clr;
  logic [N-1:0]  lane_vld;
  logic [N*KW-1:0] lane_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .cap_en   (cap_en),
    .cfg_err  (cfg_err),
    .pe_clr   (pe_clr),
    .lane_vld (lane_vld),
    .lane_idx (lane_idx)
  );

  // Output-stationary 4x4 array: A flows right along rows, B flows down columns.
  int   mat_a [4][4];
  int   mat_b [4][4];
  int   acc   [4][4];
  int   c_cap [4][4];
  int   ar    [4][4];
  int   br    [4][4];
  bit   avr   [4][4];
  bit   bvr   [4][4];
  int   a_in  [4][4];
  int   b_in  [4][4];
  bit   av_in [4][4];
  bit   bv_in [4][4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a_in[i][j]  = 0;
        b_in[i][j]  = 0;
        av_in[i][j] = 1'b0;
        bv_in[i][j] = 1'b0;
        if (j == 0) begin
          av_in[i][j] = lane_vld[i];
          a_in[i][j]  = mat_a[i][lane_idx[i*KW +: 2]];
        end else begin
          av_in[i][j] = avr[i][j-1];
          a_in[i][j]  = ar[i][j-1];
        end
        if (i == 0) begin
          bv_in[i][j] = lane_vld[j];
          b_in[i][j]  = mat_b[lane_idx[j*KW +: 2]][j];
        end else begin
          bv_in[i][j] = bvr[i-1][j];
          b_in[i][j]  = br[i-1][j];
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (pe_clr) begin
          acc[i][j] <= 0;
          ar[i][j]  <= 0;
          br[i][j]  <= 0;
          avr[i][j] <= 1'b0;
          bvr[i][j] <= 1'b0;
        end else begin
          ar[i][j]  <= a_in[i][j];
          br[i][j]  <= b_in[i][j];
          avr[i][j] <= av_in[i][j];
          bvr[i][j] <= bv_in[i][j];
          if (av_in[i][j] && bv_in[i][j])
            acc[i][j] <= acc[i][j] + a_in[i][j] * b_in[i][j];
        end
        if (cap_en)
          c_cap[i][j] <= acc[i][j];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  exp_vld [14];
  logic [31:0] exp_idx [14];
  logic [13:0] busy_seq;
  int          cnt, dn, found;

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = (i == j) ? 1 : 0;
        mat_b[i][j] = i * 4 + j + 1;
      end
    for (int c = 0; c < 14; c++) begin
      exp_vld[c] = 4'h0;
      exp_idx[c] = 32'h0;
    end
    exp_vld[2] = 4'b0001; exp_idx[2] = 32'h0000_0000;
    exp_vld[3] = 4'b0011; exp_idx[3] = 32'h0000_0001;
    exp_vld[4] = 4'b0111; exp_idx[4] = 32'h0000_0102;
    exp_vld[5] = 4'b1110; exp_idx[5] = 32'h0001_0200;
    exp_vld[6] = 4'b1100; exp_idx[6] = 32'h0102_0000;
    exp_vld[7] = 4'b1000; exp_idx[7] = 32'h0200_0000;

    // Reset state
    rst = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0;
    step(); step();
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_cap_en",  32'(cap_en),   32'd0);
    chk("rst_cfg_err", 32'(cfg_err),  32'd0);
    chk("rst_pe_clr",  32'(pe_clr),   32'd1);
    chk("rst_vld",     32'(lane_vld), 32'd0);
    chk("rst_idx",     lane_idx,      32'd0);
    rst = 1'b1;
    step();
    chk("rel_pe_clr",  32'(pe_clr),   32'd0);

    // Basic pass, k_len=3
    start = 1'b1; k_len = 8'd3;
    step();
    start = 1'b0;
    chk("p1_clear_busy", 32'(busy),     32'd1);
    chk("p1_clear_pclr", 32'(pe_clr),   32'd1);
    chk("p1_clear_vld",  32'(lane_vld), 32'd0);
    for (int c = 2; c < 14; c++) begin
      step();
      chk($sformatf("p1_vld_c%0d", c),  32'(lane_vld), 32'(exp_vld[c]));
      chk($sformatf("p1_idx_c%0d", c),  lane_idx,      exp_idx[c]);
      chk($sformatf("p1_busy_c%0d", c), 32'(busy),     32'd1);
      chk($sformatf("p1_done_c%0d", c), 32'(done),     32'(c == 13));
      chk($sformatf("p1_cap_c%0d", c),  32'(cap_en),   32'(c == 13));
    end
    step();
    chk("p1_end_busy", 32'(busy), 32'd0);
    chk("p1_end_done", 32'(done), 32'd0);

    // Zero-length start is rejected
    start = 1'b1; k_len = 8'd0;
    step();
    start = 1'b0;
    chk("k0_cfg_err", 32'(cfg_err), 32'd1);
    chk("k0_busy",    32'(busy),    32'd0);
    chk("k0_pe_clr",  32'(pe_clr),  32'd0);
    step();
    chk("k0_cfg_err_drop", 32'(cfg_err), 32'd0);
    chk("k0_busy_after",   32'(busy),    32'd0);

    // Abort at t=2, then a k_len=1 pass
    start = 1'b1; k_len = 8'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("ab_vld_t2", 32'(lane_vld), 32'b0111);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy",   32'(busy),     32'd0);
    chk("ab_pe_clr", 32'(pe_clr),   32'd1);
    chk("ab_vld",    32'(lane_vld), 32'd0);
    chk("ab_done",   32'(done),     32'd0);
    step();
    chk("ab_pe_clr_drop", 32'(pe_clr), 32'd0);
    start = 1'b1; k_len = 8'd1;
    step();
    start = 1'b0;
    cnt = 0; dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      cnt++;
      if (done) dn++;
      step();
    end
    chk("k1_busy_cycles", 32'(cnt), 32'd11);
    chk("k1_done_count",  32'(dn),  32'd1);

    // start held high: one pass, one idle cycle, then a second pass
    start = 1'b1; k_len = 8'd2;
    dn = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      busy_seq[c] = busy;
      if (c < 13 && done) dn++;
    end
    chk("hold_busy_seq", 32'(busy_seq), 32'b10_1111_1111_1111);
    chk("hold_done_cnt", 32'(dn),       32'd1);
    chk("hold_2nd_clr",  32'(pe_clr),   32'd1);
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("hold_abort_busy", 32'(busy), 32'd0);

    // Reset mid-DRAIN
    start = 1'b1; k_len = 8'd3;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("rd_busy_pre", 32'(busy),     32'd1);
    chk("rd_vld_pre",  32'(lane_vld), 32'd0);
    rst = 1'b0;
    step();
    chk("rd_busy",   32'(busy),   32'd0);
    chk("rd_pe_clr", 32'(pe_clr), 32'd1);
    chk("rd_done",   32'(done),   32'd0);
    chk("rd_cap",    32'(cap_en), 32'd0);
    step();
    chk("rd_pe_clr_hold", 32'(pe_clr), 32'd1);
    rst = 1'b1;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done || cap_en || busy) dn++;
    end
    chk("rd_quiet_after", 32'(dn), 32'd0);

    // End-to-end identity x B
    start = 1'b1; k_len = 8'd4;
    step();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (cap_en) begin
        found = 1;
        break;
      end
    end
    chk("e2e_cap_seen", 32'(found), 32'd1);
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("e2e_c%0d%0d", i, j), 32'(c_cap[i][j]), 32'(i * 4 + j + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
